// File: rtl/dmem_mmio_responder.sv
// Data-memory responder for the core's MEM stage: word RAM plus a 16-byte I/O window
// holding the LED register, a free-running cycle counter and a byte TX FIFO.
module dmem_mmio_responder #(
    parameter int unsigned DEPTH_WORDS = 128,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_FF00
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [15:0] led
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned FW = $clog2(FIFO_DEPTH);

    // 33-bit bounds so the window end cannot wrap for bases near the top of memory
    localparam logic [32:0] RAM_LIMIT = 33'(DEPTH_WORDS) << 2;
    localparam logic [32:0] MMIO_LO   = {1'b0, MMIO_BASE};
    localparam logic [32:0] MMIO_HI   = {1'b0, MMIO_BASE} + 33'd16;

    localparam logic [1:0]  OFF_LED    = 2'd0;
    localparam logic [1:0]  OFF_CYCLE  = 2'd1;
    localparam logic [1:0]  OFF_TXDATA = 2'd2;
    localparam logic [1:0]  OFF_STATUS = 2'd3;

    localparam logic [FW:0]   CNT_ONE  = (FW+1)'(1);
    localparam logic [FW:0]   CNT_FULL = (FW+1)'(FIFO_DEPTH);
    localparam logic [FW-1:0] PTR_ONE  = FW'(1);

    logic [32:0]   addr_x;
    logic          is_mmio;
    logic          is_ram;
    logic [1:0]    mmio_off;
    logic [AW-1:0] ram_idx;

    logic [31:0]   ram [DEPTH_WORDS];
    logic [7:0]    fifo_mem [FIFO_DEPTH];

    logic [31:0]   cycle_cnt;
    logic [FW-1:0] rd_ptr;
    logic [FW-1:0] wr_ptr;
    logic [FW:0]   count;
    logic [3:0]    count4;
    logic          overflow;
    logic          full;
    logic          empty;

    logic          ram_we;
    logic          led_we;
    logic          push_req;
    logic          push_ok;
    logic          drop;
    logic          pop;
    logic          ovf_clr;
    logic [31:0]   status;

    assign addr_x   = {1'b0, Addr};
    assign is_mmio  = (addr_x >= MMIO_LO) && (addr_x < MMIO_HI);
    assign is_ram   = !is_mmio && (addr_x < RAM_LIMIT);
    assign mmio_off = Addr[3:2];
    assign ram_idx  = Addr[AW+1:2];

    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);

    assign ram_we   = MemWrite && is_ram;
    assign led_we   = MemWrite && is_mmio && (mmio_off == OFF_LED);
    assign push_req = MemWrite && is_mmio && (mmio_off == OFF_TXDATA);
    assign ovf_clr  = MemWrite && is_mmio && (mmio_off == OFF_STATUS) && WriteData[2];

    assign pop     = tx_valid && tx_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge
    assign push_ok = push_req && (!full || pop);
    assign drop    = push_req && !push_ok;

    generate
        if (FW + 1 >= 4) begin : g_cnt_trunc
            assign count4 = count[3:0];
        end else begin : g_cnt_ext
            assign count4 = {{(3 - FW){1'b0}}, count};
        end
    endgenerate

    assign status = {24'b0, count4, 1'b0, overflow, empty, full};

    always_ff @(posedge CLK) begin
        if (ram_we) begin
            ram[ram_idx] <= WriteData;
        end
    end

    always_ff @(posedge CLK) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= WriteData[7:0];
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            led       <= '0;
            cycle_cnt <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (led_we) begin
                led <= WriteData[15:0];
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    assign tx_valid = !empty;
    assign tx_data  = tx_valid ? fifo_mem[rd_ptr] : 8'h00;

    always_comb begin
        ReadData = '0;
        if (is_mmio) begin
            case (mmio_off)
                OFF_LED:    ReadData = {16'b0, led};
                OFF_CYCLE:  ReadData = cycle_cnt;
                OFF_TXDATA: ReadData = '0;
                OFF_STATUS: ReadData = status;
                default:    ReadData = '0;
            endcase
        end else if (is_ram) begin
            ReadData = ram[ram_idx];
        end
    end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Bench for dmem_mmio_responder: directed scenarios plus random traffic, each cycle
// compared against a queue/array reference model of the memory map.
module tb_dmem_mmio_responder;

    localparam int          DEPTH = 128;
    localparam int          FD    = 8;
    localparam logic [31:0] BASE  = 32'hFFFF_FF00;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        MemWrite;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] led;

    dmem_mmio_responder #(
        .DEPTH_WORDS(DEPTH),
        .FIFO_DEPTH (FD),
        .MMIO_BASE  (BASE)
    ) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .MemWrite (MemWrite),
        .Addr     (Addr),
        .WriteData(WriteData),
        .ReadData (ReadData),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .led      (led)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] ram_m [DEPTH];
    logic [15:0] led_m;
    logic [31:0] cyc_m;
    logic [7:0]  q[$];
    bit          ovf_m;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        int sz;
        sz = q.size();
        if (a >= BASE && a <= BASE + 32'd15) begin
            case ((a - BASE) / 4)
                0: return {16'h0, led_m};
                1: return cyc_m;
                2: return 32'h0;
                default: return ((sz % 16) << 4) | (ovf_m << 2) | ((sz == 0) << 1) | (sz == FD);
            endcase
        end
        if (a < DEPTH * 4) return ram_m[a / 4];
        return 32'h0;
    endfunction

    task automatic model_edge(input logic we, input logic [31:0] a, input logic [31:0] wd,
                              input logic rdy);
        bit was_full;
        bit popped;
        was_full = (q.size() == FD);
        popped   = (q.size() > 0) && rdy;
        if (popped) void'(q.pop_front());
        if (we) begin
            if (a >= BASE && a <= BASE + 32'd15) begin
                case ((a - BASE) / 4)
                    0: led_m = wd[15:0];
                    2: if (!was_full || popped) q.push_back(wd[7:0]); else ovf_m = 1'b1;
                    3: if (wd[2]) ovf_m = 1'b0;
                    default: ;
                endcase
            end else if (a < DEPTH * 4) begin
                ram_m[a / 4] = wd;
            end
        end
        cyc_m = cyc_m + 32'd1;
    endtask

    // One cycle: drive at the falling edge, check before the rising edge, advance the model
    task automatic step(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic rdy);
        MemWrite  = we;
        Addr      = a;
        WriteData = wd;
        tx_ready  = rdy;
        #1;
        chk("rdata", ReadData, exp_read(a));
        chk("tx_valid", {31'b0, tx_valid}, {31'b0, q.size() != 0});
        chk("tx_data", {24'b0, tx_data}, (q.size() != 0) ? {24'b0, q[0]} : 32'h0);
        chk("led", {16'b0, led}, {16'b0, led_m});
        @(posedge CLK);
        model_edge(we, a, wd, rdy);
        @(negedge CLK);
    endtask

    task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
        MemWrite = 1'b0;
        Addr     = a;
        tx_ready = 1'b0;
        #1;
        chk(tag, ReadData, exp);
        @(posedge CLK);
        model_edge(1'b0, a, 32'h0, 1'b0);
        @(negedge CLK);
    endtask

    task automatic model_reset();
        led_m = '0;
        cyc_m = '0;
        q.delete();
        ovf_m = 1'b0;
    endtask

    task automatic do_reset();
        MemWrite = 1'b0;
        tx_ready = 1'b0;
        Reset    = 1'b1;
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        Reset = 1'b0;
    endtask

    logic [31:0] c0;
    logic [31:0] c1;

    initial begin
        MemWrite  = 1'b0;
        Addr      = '0;
        WriteData = '0;
        tx_ready  = 1'b0;
        for (int i = 0; i < DEPTH; i++) ram_m[i] = '0;
        do_reset();

        chk("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
        chk("rst_tx_data", {24'b0, tx_data}, 32'h0);
        chk("rst_led", {16'b0, led}, 32'h0);
        peek("rst_status", BASE + 32'd12, 32'h0000_0002);

        // RAM is not reset: zero every word without checking the undefined old contents
        for (int i = 0; i < DEPTH; i++) begin
            MemWrite = 1'b1; Addr = i * 4; WriteData = '0; tx_ready = 1'b0;
            @(posedge CLK);
            model_edge(1'b1, i * 4, 32'h0, 1'b0);
            @(negedge CLK);
        end

        step(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
        peek("ram_10", 32'h10, 32'hDEAD_BEEF);
        peek("ram_13", 32'h13, 32'hDEAD_BEEF);
        peek("ram_14", 32'h14, 32'h0);
        step(1'b1, 32'h400, 32'hFFFF_FFFF, 1'b0);
        peek("unmapped_400", 32'h400, 32'h0);
        peek("ram_alias_0", 32'h0, 32'h0);

        step(1'b1, BASE, 32'h1234_ABCD, 1'b0);
        chk("led_wr", {16'b0, led}, 32'h0000_ABCD);
        peek("led_rd", BASE, 32'h0000_ABCD);

        MemWrite = 1'b0; Addr = BASE + 32'd4; #1; c0 = ReadData;
        @(posedge CLK); model_edge(1'b0, Addr, 32'h0, 1'b0); @(negedge CLK);
        for (int i = 0; i < 9; i++) step(1'b0, 32'h20, 32'h0, 1'b0);
        Addr = BASE + 32'd4; #1; c1 = ReadData;
        chk("cyc_diff", c1 - c0, 32'd10);
        @(posedge CLK); model_edge(1'b0, Addr, 32'h0, 1'b0); @(negedge CLK);

        do_reset();
        peek("cyc_after_rst", BASE + 32'd4, 32'h0);

        for (int i = 0; i < 8; i++) step(1'b1, BASE + 32'd8, 32'h41 + i, 1'b0);
        chk("fill_head", {24'b0, tx_data}, 32'h41);
        peek("fill_status", BASE + 32'd12, 32'h0000_0081);
        step(1'b1, BASE + 32'd8, 32'h49, 1'b0);
        peek("ovf_status", BASE + 32'd12, 32'h0000_0085);
        step(1'b1, BASE + 32'd12, 32'h4, 1'b0);
        peek("ovf_clr", BASE + 32'd12, 32'h0000_0081);

        for (int i = 0; i < 8; i++) begin
            tx_ready = 1'b1; #1;
            chk("drain_byte", {24'b0, tx_data}, 32'h41 + i);
            step(1'b0, 32'h20, 32'h0, 1'b1);
        end
        chk("drain_valid", {31'b0, tx_valid}, 32'h0);
        peek("drain_status", BASE + 32'd12, 32'h0000_0002);

        for (int i = 0; i < 8; i++) step(1'b1, BASE + 32'd8, 32'h61 + i, 1'b0);
        step(1'b1, BASE + 32'd8, 32'h5A, 1'b1);
        peek("pushpop_status", BASE + 32'd12, 32'h0000_0081);
        for (int i = 0; i < 8; i++) begin
            tx_ready = 1'b1; #1;
            chk("pushpop_byte", {24'b0, tx_data}, (i == 7) ? 32'h5A : 32'h62 + i);
            step(1'b0, 32'h20, 32'h0, 1'b1);
        end
        peek("pushpop_end", BASE + 32'd12, 32'h0000_0002);

        step(1'b1, BASE, 32'h0000_5555, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, BASE + 32'd8, 32'h30 + i, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h20, 32'h0, 1'b1);
        peek("pre_rst_status", BASE + 32'd12, 32'h0000_0050);
        tx_ready = 1'b1;
        @(posedge CLK);
        #2;
        Reset = 1'b1;
        #1;
        chk("arst_tx_valid", {31'b0, tx_valid}, 32'h0);
        chk("arst_tx_data", {24'b0, tx_data}, 32'h0);
        chk("arst_led", {16'b0, led}, 32'h0);
        model_reset();
        tx_ready = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        Reset = 1'b0;
        peek("arst_status", BASE + 32'd12, 32'h0000_0002);

        for (int n = 0; n < 600; n++) begin
            logic [31:0] a;
            logic [31:0] wd;
            int          sel;
            sel = $urandom_range(0, 9);
            wd  = $urandom;
            if (sel < 4)       a = ($urandom_range(0, DEPTH - 1) * 4) + $urandom_range(0, 3);
            else if (sel < 8)  a = BASE + $urandom_range(0, 15);
            else if (sel == 8) a = $urandom_range(32'h200, 32'hFFFF_FE00);
            else               a = BASE + 32'd16 + $urandom_range(0, 239);
            step(($urandom_range(0, 1) == 1), a, wd, ($urandom_range(0, 2) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
